line_raster_engine: RTL
=======================

# line_raster_engine

Parametrised successor to the single-line drawer: a handshaked Bresenham rasteriser that accepts line requests in all eight octants and also has a rectangular fill/clear mode. It emits one pixel coordinate per accepted transfer with a per-request colour. It sits between a command source (FSM or animation controller) and the VGA frame buffer's `x`/`y`/`pixel_color`/`pixel_write` port.

## Interface
- `COORD_W`, 11: width of every coordinate port.
- `X_MAX`, 640: fill-mode column count; fill x runs 0..X_MAX-1.
- `Y_MAX`, 480: fill-mode row count; fill y runs 0..Y_MAX-1.

- `clk`  in  1  the only clock; all logic on its posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `mode`  in  1  0 = line, 1 = fill whole X_MAX×Y_MAX area.
- `color_in`  in  1  colour captured with the request.
- `x0`, `y0`, `x1`, `y1`  in  COORD_W each  unsigned endpoints; captured on start; ignored in fill mode.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  single-cycle pulse after the last pixel transfer.
- `pixel_valid`  out  1  `x`/`y`/`pixel_color` hold a pixel.
- `pixel_ready`  in  1  sink accepts; a transfer happens when valid && ready.
- `x`, `y`  out  COORD_W  current pixel.
- `pixel_color`  out  1  captured `color_in`.

## Operation
- States: IDLE, SETUP, DRAW, FILL, DONE.
- IDLE: when `start` is high, latch inputs. Go to SETUP if mode = 0, else go to FILL with x = y = 0.
- SETUP (1 cycle) computes the Bresenham terms:
  - dx = |x1−x0|, dy = −|y1−y0|
  - sx = (x0<x1) ? +1 : −1, sy = (y0<y1) ? +1 : −1
  - err = dx + dy
  - x = x0, y = y0
  - Then go to DRAW.
- DRAW: `pixel_valid` = 1. On each transfer:
  - If (x,y) == (x1,y1), go to DONE.
  - Otherwise, with e2 = 2·err:
    - if e2 ≥ dy: err += dy, x += sx
    - if e2 ≤ dx: err += dx, y += sy
    - Both updates use the pre-update err within the same cycle.
- FILL: `pixel_valid` = 1, raster order with x fastest. On a transfer at x = X_MAX−1, set x = 0 and y += 1. A transfer at (X_MAX−1, Y_MAX−1) goes to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Arithmetic width: dx, dy and err are signed COORD_W+2 bits; e2 is COORD_W+3 bits. No overflow is possible for any endpoints.
- Pixel count for a line is max(|Δx|,|Δy|)+1. A degenerate line (x0=x1, y0=y1) emits exactly one pixel.
- Backpressure: while `pixel_valid` && !`pixel_ready`, `x`, `y`, `pixel_color` and all internal state are frozen.
- `start` while not IDLE is ignored. It is not queued and does not disturb latched inputs.
- Endpoint inputs may change after the start cycle with no effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `pixel_valid` 0, `x` 0, `y` 0, `pixel_color` 0. err, dx, dy are 0.
- `reset` mid-operation aborts immediately. No `done` pulse is produced and the next cycle is IDLE.
- Line latency: start accepted at cycle N, SETUP at N+1, first `pixel_valid` at N+2.
- Fill latency: first `pixel_valid` at N+1.
- Sustained throughput is 1 pixel/cycle while `pixel_ready` = 1.
- `done` is asserted the cycle after the final transfer; `busy` drops in that same cycle.
- A new `start` is accepted in the IDLE cycle that follows DONE, so the minimum request spacing is last-transfer + 2 cycles.
- `busy` = 1 in SETUP, DRAW and FILL.

## Structure
- Package `line_raster_pkg`:
  - `coord_t` (logic [COORD_W-1:0] via a package parameter default of 11)
  - `state_e` enum {IDLE, SETUP, DRAW, FILL, DONE}
  - `mode_e` enum {MODE_LINE, MODE_FILL}
- One sub-module, `bresenham_step`: combinational.
  - Inputs: x, y, err, dx, dy, sx, sy.
  - Outputs: next x, y, err, and `last` (point equals endpoint).
  - The top holds the FSM, registers and handshake.

## Test plan
- Line (40,40)→(70,50), ready = 1 → 31 transfers; first (40,40), last (70,50); `done` pulses 1 cycle after the last transfer.
- Steep negative line (10,60)→(5,20) → 41 transfers; y strictly decreasing by 1 each transfer; x monotonically non-increasing; ends at (5,20).
- Degenerate line (7,7)→(7,7) → exactly one transfer at (7,7), then `done`. Same line with `start` re-asserted during `busy` → no second request.
- Backpressure on (0,0)→(3,3) with `pixel_ready` toggling 1,0,0,1,… → output held on stall cycles; exactly (0,0),(1,1),(2,2),(3,3) transferred.
- Fill mode with X_MAX = 4, Y_MAX = 3, `color_in` = 1 → 12 transfers in raster order (0,0)…(3,2); `pixel_color` = 1 throughout.
- `reset` asserted at the 5th pixel of (0,0)→(20,0) → next cycle all outputs at reset values, no `done`; a new start then draws a full line correctly.

Source files
------------

// File: rtl/line_raster_pkg.sv
// Shared types for the line/fill rasteriser: coordinate type,
// FSM state encoding and request mode.
package line_raster_pkg;

    parameter int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRAW,
        FILL,
        DONE
    } state_e;

    typedef enum logic {
        MODE_LINE,
        MODE_FILL
    } mode_e;

endpackage

// File: rtl/line_raster_engine_step.sv
// One combinational Bresenham step: next point, next error term,
// and whether the current point is the line endpoint.
module bresenham_step #(
    parameter int COORD_W = 11
) (
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic [COORD_W-1:0]        x_end,
    input  logic [COORD_W-1:0]        y_end,
    input  logic signed [COORD_W+1:0] err,
    input  logic signed [COORD_W+1:0] dx,
    input  logic signed [COORD_W+1:0] dy,
    input  logic                      sx,
    input  logic                      sy,
    output logic [COORD_W-1:0]        x_next,
    output logic [COORD_W-1:0]        y_next,
    output logic signed [COORD_W+1:0] err_next,
    output logic                      last
);

    localparam logic [COORD_W-1:0] ONE = 1;
    localparam logic signed [COORD_W+1:0] ZERO = '0;

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_w;
    logic signed [COORD_W+2:0] dy_w;
    logic signed [COORD_W+1:0] add_x;
    logic signed [COORD_W+1:0] add_y;
    logic                      step_x;
    logic                      step_y;

    // sx/sy set means step in the negative direction
    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {dx[COORD_W+1], dx};
        dy_w     = {dy[COORD_W+1], dy};
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        add_x    = step_x ? dy : ZERO;
        add_y    = step_y ? dx : ZERO;
        err_next = err + add_x + add_y;
        x_next   = x;
        y_next   = y;
        if (step_x) x_next = sx ? x - ONE : x + ONE;
        if (step_y) y_next = sy ? y - ONE : y + ONE;
        last     = (x == x_end) && (y == y_end);
    end

endmodule

// File: rtl/line_raster_engine.sv
// Handshaked Bresenham line rasteriser with a full-area fill mode,
// feeding one pixel per valid/ready transfer to a frame buffer port.
module line_raster_engine #(
    parameter int COORD_W = 11,
    parameter int X_MAX   = 640,
    parameter int Y_MAX   = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               color_in,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               done,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_color
);

    import line_raster_pkg::*;

    localparam int SW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE    = 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_MAX - 1);

    state_e state;

    logic [COORD_W-1:0] xa, ya, xb, yb;
    logic signed [SW-1:0] err, dx, dy;
    logic sx, sy;

    logic signed [SW-1:0] dx_raw, dy_raw, adx, ady;
    logic [COORD_W-1:0] x_step, y_step;
    logic signed [SW-1:0] err_step;
    logic last;

    always_comb begin
        dx_raw = signed'({2'b00, xb}) - signed'({2'b00, xa});
        dy_raw = signed'({2'b00, yb}) - signed'({2'b00, ya});
        adx    = dx_raw[SW-1] ? -dx_raw : dx_raw;
        ady    = dy_raw[SW-1] ? -dy_raw : dy_raw;
    end

    bresenham_step #(.COORD_W(COORD_W)) u_step (
        .x        (x),
        .y        (y),
        .x_end    (xb),
        .y_end    (yb),
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .sx       (sx),
        .sy       (sy),
        .x_next   (x_step),
        .y_next   (y_step),
        .err_next (err_step),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_color <= 1'b0;
            x           <= '0;
            y           <= '0;
            xa          <= '0;
            ya          <= '0;
            xb          <= '0;
            yb          <= '0;
            err         <= '0;
            dx          <= '0;
            dy          <= '0;
            sx          <= 1'b0;
            sy          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xa          <= x0;
                        ya          <= y0;
                        xb          <= x1;
                        yb          <= y1;
                        pixel_color <= color_in;
                        busy        <= 1'b1;
                        if (mode_e'(mode) == MODE_FILL) begin
                            x           <= '0;
                            y           <= '0;
                            pixel_valid <= 1'b1;
                            state       <= FILL;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    dx          <= adx;
                    dy          <= -ady;
                    err         <= adx - ady;
                    sx          <= !(xa < xb);
                    sy          <= !(ya < yb);
                    x           <= xa;
                    y           <= ya;
                    pixel_valid <= 1'b1;
                    state       <= DRAW;
                end
                DRAW: begin
                    if (pixel_ready) begin
                        if (last) begin
                            pixel_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            x   <= x_step;
                            y   <= y_step;
                            err <= err_step;
                        end
                    end
                end
                FILL: begin
                    if (pixel_ready) begin
                        if (x == X_LAST) begin
                            if (y == Y_LAST) begin
                                pixel_valid <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else begin
                                x <= '0;
                                y <= y + ONE;
                            end
                        end else begin
                            x <= x + ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
